// File: rtl/mio_pkg.sv
// Shared types for the MIO bus controller: FSM states, grant owner and the
// request payload that is muxed from the CPU or debug port at grant time.
package mio_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [DATA_W-1:0] DEAD_BEEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE, ACC, IOW, RSP} state_t;

  typedef enum logic {CPU, DBG} grant_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mio_req_t;

endpackage

// File: rtl/mio_addr_decode.sv
// Combinational address decode: RAM window at the bottom of the map, IO window
// by base/mask match. Anything else is unmapped.
module mio_addr_decode
  import mio_pkg::*;
#(
  parameter int unsigned      RAM_AW  = 10,
  parameter logic [ADDR_W-1:0] IO_BASE = 32'hE000_0000,
  parameter logic [ADDR_W-1:0] IO_MASK = 32'hF000_0000
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              ram_hit_c,
  output logic              io_hit_c
);

  // RAM never aliases: every bit above the word index must be zero.
  assign ram_hit_c = (addr[ADDR_W-1:RAM_AW+2] == '0);
  assign io_hit_c  = ~ram_hit_c & ((addr & IO_MASK) == IO_BASE);

endmodule

// File: rtl/mio_bus_ctrl.sv
// MIO bus controller: round-robin arbitration of CPU and debug ports onto one
// RAM_B port and one IO bus. Optional IO ack watchdog under MIO_TIMEOUT_EN.
module mio_bus_ctrl
  import mio_pkg::*;
#(
  parameter int unsigned       RAM_AW  = 10,
  parameter logic [ADDR_W-1:0] IO_BASE = 32'hE000_0000,
  parameter logic [ADDR_W-1:0] IO_MASK = 32'hF000_0000
`ifdef MIO_TIMEOUT_EN
  , parameter int unsigned     TIMEOUT = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,

  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ready,

  output logic [RAM_AW-1:0] ram_addra,
  output logic              ram_wea,
  output logic [DATA_W-1:0] ram_dina,
  input  logic [DATA_W-1:0] ram_douta,

  output logic              io_req,
  output logic              io_we,
  output logic [ADDR_W-1:0] io_addr,
  output logic [DATA_W-1:0] io_wdata,
  input  logic [DATA_W-1:0] io_rdata,
  input  logic              io_ack,

  output logic              bus_err
);

`ifdef MIO_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  state_t            state;
  grant_t            last_grant;
  logic              lat_we;
  logic              lat_ram;
  logic [DATA_W-1:0] cap_data;

  logic              cpu_v_c;
  logic              dbg_v_c;
  grant_t            pick_c;
  mio_req_t          sel_c;
  logic              ram_hit_c;
  logic              io_hit_c;
  logic [DATA_W-1:0] rsp_data_c;

  // A port whose ready is high this cycle is still holding its finished request.
  always_comb begin
    cpu_v_c = cpu_req & ~cpu_ready;
    dbg_v_c = dbg_req & ~dbg_ready;
    pick_c  = CPU;
    if (cpu_v_c && dbg_v_c) begin
      pick_c = (last_grant == CPU) ? DBG : CPU;
    end else if (dbg_v_c) begin
      pick_c = DBG;
    end
    sel_c = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
    if (pick_c == DBG) begin
      sel_c = '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata};
    end
  end

  mio_addr_decode #(
    .RAM_AW  (RAM_AW),
    .IO_BASE (IO_BASE),
    .IO_MASK (IO_MASK)
  ) u_decode (
    .addr      (sel_c.addr),
    .ram_hit_c (ram_hit_c),
    .io_hit_c  (io_hit_c)
  );

  // RAM_B data is valid in RSP, one cycle after the ACC address cycle.
  assign rsp_data_c = lat_ram ? ram_douta : cap_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= DBG;
      lat_we     <= 1'b0;
      lat_ram    <= 1'b0;
      cap_data   <= '0;
      cpu_rdata  <= '0;
      cpu_ready  <= 1'b0;
      dbg_rdata  <= '0;
      dbg_ready  <= 1'b0;
      ram_addra  <= '0;
      ram_wea    <= 1'b0;
      ram_dina   <= '0;
      io_req     <= 1'b0;
      io_we      <= 1'b0;
      io_addr    <= '0;
      io_wdata   <= '0;
      bus_err    <= 1'b0;
`ifdef MIO_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      cpu_ready <= 1'b0;
      dbg_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_v_c || dbg_v_c) begin
            last_grant <= pick_c;
            lat_we     <= sel_c.we;
            lat_ram    <= ram_hit_c;
            if (ram_hit_c) begin
              ram_addra <= sel_c.addr[RAM_AW+1:2];
              ram_dina  <= sel_c.wdata;
              ram_wea   <= sel_c.we;
              state     <= ACC;
            end else if (io_hit_c) begin
              io_req   <= 1'b1;
              io_we    <= sel_c.we;
              io_addr  <= sel_c.addr;
              io_wdata <= sel_c.wdata;
`ifdef MIO_TIMEOUT_EN
              tmo_cnt  <= '0;
`endif
              state    <= IOW;
            end else begin
              cap_data <= '0;
              bus_err  <= 1'b1;
              state    <= RSP;
            end
          end
        end
        ACC: begin
          ram_wea <= 1'b0;
          state   <= RSP;
        end
        IOW: begin
          if (io_ack) begin
            cap_data <= io_rdata;
            io_req   <= 1'b0;
            state    <= RSP;
          end
`ifdef MIO_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            cap_data <= DEAD_BEEF;
            bus_err  <= 1'b1;
            io_req   <= 1'b0;
            state    <= RSP;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end
        RSP: begin
          if (last_grant == CPU) begin
            cpu_ready <= 1'b1;
            if (!lat_we) cpu_rdata <= rsp_data_c;
          end else begin
            dbg_ready <= 1'b1;
            if (!lat_we) dbg_rdata <= rsp_data_c;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Self-checking bench for mio_bus_ctrl: directed cases plus randomized traffic
// checked against a word-array memory model, a scripted IO responder and a latency model.
`timescale 1ns/1ps
module tb_mio_bus_ctrl;

  localparam int unsigned RAM_AW    = 10;
  localparam int unsigned RAM_WORDS = 1 << RAM_AW;
  localparam int unsigned RAM_BYTES = 4 * RAM_WORDS;
  localparam int          BOUND     = 200;
  localparam int          R_RAM = 0, R_IO = 1, R_UNM = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, dbg_addr, dbg_wdata, dbg_rdata;
  logic        cpu_ready, dbg_ready;
  logic [RAM_AW-1:0] ram_addra;
  logic        ram_wea;
  logic [31:0] ram_dina, ram_douta;
  logic        io_req, io_we, io_ack;
  logic [31:0] io_addr, io_wdata, io_rdata;
  logic        bus_err;

  mio_bus_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_rdata (dbg_rdata),
    .dbg_ready (dbg_ready),
    .ram_addra (ram_addra),
    .ram_wea   (ram_wea),
    .ram_dina  (ram_dina),
    .ram_douta (ram_douta),
    .io_req    (io_req),
    .io_we     (io_we),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata),
    .io_ack    (io_ack),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  // RAM_B stand-in: synchronous write, registered read (one-cycle latency).
  bit [31:0] mem [RAM_WORDS];
  always @(posedge clk) begin
    if (ram_wea) mem[ram_addra] <= ram_dina;
    ram_douta <= mem[ram_addra];
  end

  // Reference model state.
  bit [31:0]   ref_mem [RAM_WORDS];
  logic [31:0] last_rd [2];
  bit          exp_err;
  bit          order_q [$];

  int n_checks = 0;
  int n_errors = 0;

  // Activity monitors sampled mid-cycle.
  int          wea_cnt = 0;
  int          ioreq_cyc = 0;
  int          rdy_cnt = 0;
  logic [RAM_AW-1:0] wea_addr = '0;
  always @(negedge clk) begin
    if (ram_wea) begin
      wea_cnt  <= wea_cnt + 1;
      wea_addr <= ram_addra;
    end
    if (io_req) ioreq_cyc <= ioreq_cyc + 1;
    if (cpu_ready || dbg_ready) rdy_cnt <= rdy_cnt + 1;
  end

  // Scripted IO device: acks after io_delay waiting cycles with io_resp.
  bit          io_en;
  int          io_delay;
  int          io_wait;
  logic [31:0] io_resp;
  logic [31:0] log_addr, log_wdata;
  logic        log_we;
  initial begin
    io_ack = 1'b0; io_rdata = '0; io_wait = 0;
    log_addr = '0; log_wdata = '0; log_we = 1'b0;
    forever begin
      @(negedge clk);
      io_ack = 1'b0;
      if (!io_req) begin
        io_wait = io_delay;
      end else if (io_en) begin
        if (io_wait == 0) begin
          io_ack    = 1'b1;
          io_rdata  = io_resp;
          log_addr  = io_addr;
          log_we    = io_we;
          log_wdata = io_wdata;
          io_wait   = io_delay;
        end else begin
          io_wait = io_wait - 1;
        end
      end
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int region(input logic [31:0] a);
    if (a < RAM_BYTES) return R_RAM;
    if ((a >> 28) == 32'hE) return R_IO;
    return R_UNM;
  endfunction

  // One request/ready handshake on port p (0=CPU, 1=DBG); lat counts edges to ready.
  task automatic xfer(input bit p, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rd, output int lat);
    bit   seen;
    logic own;
    seen = 1'b0; lat = 0; rd = '0;
    @(negedge clk);
    if (!p) begin cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1; end
    else    begin dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1'b1; end
    while (!seen && lat < BOUND) begin
      @(posedge clk); #1;
      lat++;
      own = p ? dbg_ready : cpu_ready;
      if (own) begin
        seen = 1'b1;
        rd   = p ? dbg_rdata : cpu_rdata;
        order_q.push_back(p);
        chk_eq("single_ready", 32'(cpu_ready & dbg_ready), 32'd0);
      end
    end
    if (!p) cpu_req = 1'b0; else dbg_req = 1'b0;
    chk_eq("ready_seen", 32'(seen), 32'd1);
    if (seen) begin
      @(posedge clk); #1;
      chk_eq("ready_pulse", 32'(p ? dbg_ready : cpu_ready), 32'd0);
    end
  endtask

  // Access with expectations from the model; solo accesses also check latency and strobes.
  task automatic op(input bit p, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                    input bit solo, input int dly, input logic [31:0] ioval);
    int          kind, exp_lat, lat, wea0, ioq0;
    logic [31:0] exp_rd, rd;
    kind    = region(addr);
    exp_rd  = last_rd[p];
    wea0    = wea_cnt;
    ioq0    = ioreq_cyc;
    exp_lat = 3;
    if (kind == R_RAM) begin
      if (we) ref_mem[int'(addr >> 2)] = wdata;
      else    exp_rd = ref_mem[int'(addr >> 2)];
    end else if (kind == R_IO) begin
      io_delay = dly;
      io_resp  = ioval;
      exp_lat  = dly + 3;
      if (!we) exp_rd = ioval;
    end else begin
      exp_lat = 2;
      exp_err = 1'b1;
      if (!we) exp_rd = '0;
    end
    xfer(p, we, addr, wdata, rd, lat);
    last_rd[p] = exp_rd;
    chk_eq(p ? "dbg_rdata" : "cpu_rdata", rd, exp_rd);
    chk_eq("bus_err", 32'(bus_err), 32'(exp_err));
    if (solo) begin
      chk_eq("latency", 32'(lat), 32'(exp_lat));
      if (kind == R_RAM) begin
        chk_eq("wea_cycles", 32'(wea_cnt - wea0), we ? 32'd1 : 32'd0);
      end else if (kind == R_IO) begin
        chk_eq("io_addr", log_addr, addr);
        chk_eq("io_we", 32'(log_we), 32'(we));
        if (we) chk_eq("io_wdata", log_wdata, wdata);
        chk_eq("io_req_dropped", 32'(io_req), 32'd0);
      end else begin
        chk_eq("no_strobe", 32'(wea_cnt - wea0 + ioreq_cyc - ioq0), 32'd0);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    exp_err = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] a, d, rd;
    bit          p, w;
    int          sel, lat, rdy0;

    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    io_en = 1'b1; io_delay = 0; io_resp = '0;
    exp_err = 1'b0; last_rd[0] = '0; last_rd[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    chk_eq("rst_dbg_ready", 32'(dbg_ready), 32'd0);
    chk_eq("rst_io_req", 32'(io_req), 32'd0);
    chk_eq("rst_ram_wea", 32'(ram_wea), 32'd0);
    chk_eq("rst_bus_err", 32'(bus_err), 32'd0);
    chk_eq("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk_eq("rst_dbg_rdata", dbg_rdata, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Loader preloads word 4, CPU reads it back.
    op(1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678, 1'b1, 0, '0);
    op(1'b0, 1'b0, 32'h0000_0010, '0, 1'b1, 0, '0);
    op(1'b0, 1'b1, 32'h0000_0008, 32'hCAFE_F00D, 1'b1, 0, '0);
    chk_eq("wea_addr", 32'(wea_addr), 32'd2);
    op(1'b0, 1'b0, 32'h0000_0008, '0, 1'b1, 0, '0);
    // Top RAM word; low address bits ignored.
    op(1'b1, 1'b1, 32'h0000_0FFF, 32'h0BAD_F00D, 1'b1, 0, '0);
    op(1'b0, 1'b0, 32'h0000_0FFC, '0, 1'b1, 0, '0);

    // Round robin: last grant DBG, then both ports request twice in lockstep.
    op(1'b1, 1'b0, 32'h0000_0010, '0, 1'b1, 0, '0);
    order_q.delete();
    fork
      begin
        op(1'b0, 1'b0, 32'h0000_0010, '0, 1'b0, 0, '0);
        op(1'b0, 1'b1, 32'h0000_0020, 32'h1111_0000, 1'b0, 0, '0);
      end
      begin
        op(1'b1, 1'b0, 32'h0000_0008, '0, 1'b0, 0, '0);
        op(1'b1, 1'b1, 32'h0000_0024, 32'h2222_0000, 1'b0, 0, '0);
      end
    join
    chk_eq("rr_count", 32'(order_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < order_q.size(); i++) begin
      chk_eq($sformatf("rr_order%0d", i), 32'(order_q[i]), 32'(i % 2));
    end

    // IO accesses.
    op(1'b0, 1'b0, 32'hE000_0004, '0, 1'b1, 5, 32'hA5A5_0001);
    op(1'b1, 1'b1, 32'hE000_0100, 32'h55AA_0001, 1'b1, 2, '0);
    op(1'b1, 1'b0, 32'hE123_4568, '0, 1'b1, 0, 32'h0F0F_0F0F);

    // Unmapped: just past RAM, mid map, above IO window.
    op(1'b0, 1'b0, 32'h0000_1000, '0, 1'b1, 0, '0);
    op(1'b0, 1'b0, 32'h4000_0000, '0, 1'b1, 0, '0);
    op(1'b1, 1'b1, 32'hF000_0000, 32'h1, 1'b1, 0, '0);
    op(1'b0, 1'b0, 32'h0000_0010, '0, 1'b1, 0, '0);

    // Reset while waiting on an IO ack that never comes.
    io_en = 1'b0;
    io_delay = 0;
    @(negedge clk);
    cpu_we = 1'b0; cpu_addr = 32'hE000_0040; cpu_req = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk_eq("iow_active", 32'(io_req), 32'd1);
    rdy0 = rdy_cnt;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk_eq("rst_io_req_drop", 32'(io_req), 32'd0);
    chk_eq("rst_bus_err_clr", 32'(bus_err), 32'd0);
    @(negedge clk); rst = 1'b0; cpu_req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk_eq("rst_no_ready", 32'(rdy_cnt - rdy0), 32'd0);
    chk_eq("rst_rdata_clr", cpu_rdata, 32'd0);
    io_en = 1'b1;
    exp_err = 1'b0; last_rd[0] = '0; last_rd[1] = '0;

    // Random single-port traffic over all regions.
    for (int i = 0; i < 80; i++) begin
      p   = 1'($urandom_range(0, 1));
      w   = 1'($urandom_range(0, 1));
      d   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel <= 5)      a = $urandom_range(0, RAM_BYTES - 1);
      else if (sel <= 7) a = 32'hE000_0000 | ($urandom & 32'h0FFF_FFFF);
      else if (sel == 8) a = $urandom_range(32'h0000_1000, 32'hDFFF_FFFF);
      else               a = 32'hF000_0000 | ($urandom & 32'h0FFF_FFFF);
      op(p, w, a, d, 1'b1, $urandom_range(0, 6), $urandom);
    end

    // Random concurrent RAM traffic: CPU on even words, debug on odd words.
    for (int r = 0; r < 15; r++) begin
      fork
        begin
          for (int k = 0; k < 3; k++) begin
            op(1'b0, 1'($urandom_range(0, 1)), 32'(8 * $urandom_range(0, RAM_WORDS / 2 - 1)),
               $urandom, 1'b0, 0, '0);
          end
        end
        begin
          for (int k = 0; k < 3; k++) begin
            op(1'b1, 1'($urandom_range(0, 1)), 32'(8 * $urandom_range(0, RAM_WORDS / 2 - 1) + 4),
               $urandom, 1'b0, 0, '0);
          end
        end
      join
    end

`ifdef MIO_TIMEOUT_EN
    // Watchdog: no ack ever, expect the poison value after 16 waiting cycles.
    do_reset();
    io_en = 1'b0;
    xfer(1'b0, 1'b0, 32'hE000_0008, '0, rd, lat);
    chk_eq("tmo_rdata", rd, 32'hDEAD_BEEF);
    chk_eq("tmo_latency", 32'(lat), 32'd18);
    chk_eq("tmo_bus_err", 32'(bus_err), 32'd1);
    chk_eq("tmo_io_req", 32'(io_req), 32'd0);
    io_en = 1'b1;
`else
    do_reset();
    xfer(1'b0, 1'b0, 32'h0000_0010, '0, rd, lat);
    chk_eq("post_rst_rdata", rd, ref_mem[4]);
    chk_eq("post_rst_latency", 32'(lat), 32'd3);
    chk_eq("post_rst_bus_err", 32'(bus_err), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
